// File: rtl/note_lane_manager.sv
// note_lane_manager
//   Multi-slot falling-note engine. Up to NUM_SLOTS notes fall concurrently
//   across 2^COL_W columns. Notes spawn on divider ticks when the random word
//   beats a threshold and a minimum spawn spacing has elapsed. Player presses
//   are judged against a y hit window. Notes reaching Y_MAX are retired as
//   missed.
//
//   Optional feature macro: NOTE_LANE_STATS_EN adds saturating hit/miss
//   counters (hit_count, miss_count). With the macro undefined those ports and
//   counters are absent.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   start        run enable; low freezes state and clears event pulses
//   speed[19:0]  tick divider, a tick occurs every speed+1 cycles
//   rand_word    16-bit random word, sampled on tick cycles only
//   hit_valid    one-cycle player press
//   hit_column   pressed column
//   note_active  per-slot valid
//   note_col     packed columns, slot i at [i*COL_W +: COL_W]
//   note_y       packed y positions, slot i at [i*Y_W +: Y_W]
//   spawned, hit_ok, hit_bad, note_missed  registered one-cycle event pulses
//   hit_count, miss_count  (NOTE_LANE_STATS_EN only) saturating event counters
module note_lane_manager #(
  parameter int          NUM_SLOTS       = 4,
  parameter int          COL_W           = 2,
  parameter int          Y_W             = 10,
  parameter int          Y_MAX           = 480,
  parameter int          HIT_LO          = 440,
  parameter int          HIT_HI          = 470,
  parameter logic [15:0] SPAWN_THRESHOLD = 16'h8000,
  parameter int          MIN_GAP         = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [19:0]                speed,
  input  logic [15:0]                rand_word,
  input  logic                       hit_valid,
  input  logic [COL_W-1:0]           hit_column,
  output logic [NUM_SLOTS-1:0]       note_active,
  output logic [NUM_SLOTS*COL_W-1:0] note_col,
  output logic [NUM_SLOTS*Y_W-1:0]   note_y,
  output logic                       spawned,
  output logic                       hit_ok,
  output logic                       hit_bad,
  output logic                       note_missed
`ifdef NOTE_LANE_STATS_EN
  ,
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count
`endif
);

  localparam int             GAP_W    = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(MIN_GAP);
  localparam logic [Y_W-1:0] Y_RETIRE = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] HIT_LO_Y = Y_W'(HIT_LO);
  localparam logic [Y_W-1:0] HIT_HI_Y = Y_W'(HIT_HI);

  logic [19:0]          counter_reg, counter_next;
  logic [GAP_W-1:0]     gap_reg, gap_next;
  logic [NUM_SLOTS-1:0] active_reg, active_next;
  logic [COL_W-1:0]     col_reg [NUM_SLOTS];
  logic [COL_W-1:0]     col_next [NUM_SLOTS];
  logic [Y_W-1:0]       y_reg [NUM_SLOTS];
  logic [Y_W-1:0]       y_next [NUM_SLOTS];
  logic                 spawned_reg, spawned_next;
  logic                 hit_ok_reg, hit_ok_next;
  logic                 hit_bad_reg, hit_bad_next;
  logic                 missed_reg, missed_next;

  logic                 tick;
  logic                 spawn;
  logic                 hit_any;
  logic                 free_any;
  logic [Y_W-1:0]       hit_best_y;
  logic [NUM_SLOTS-1:0] hit_mask;
  logic [NUM_SLOTS-1:0] free_mask;

  always_comb begin
    tick         = start && (counter_reg >= speed);
    counter_next = counter_reg;
    if (tick) begin
      counter_next = '0;
    end else if (start) begin
      counter_next = counter_reg + 20'd1;
    end

    // Hit candidate search and lowest free slot, both on pre-edge state.
    // Strict '>' keeps the lowest index on equal y.
    hit_any    = 1'b0;
    hit_best_y = '0;
    hit_mask   = '0;
    free_any   = 1'b0;
    free_mask  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (start && hit_valid && active_reg[i] && (col_reg[i] == hit_column)
          && (y_reg[i] >= HIT_LO_Y) && (y_reg[i] <= HIT_HI_Y)
          && (!hit_any || (y_reg[i] > hit_best_y))) begin
        hit_any     = 1'b1;
        hit_best_y  = y_reg[i];
        hit_mask    = '0;
        hit_mask[i] = 1'b1;
      end
      if (!active_reg[i] && !free_any) begin
        free_any     = 1'b1;
        free_mask[i] = 1'b1;
      end
    end

    spawn = tick && (rand_word > SPAWN_THRESHOLD) && (gap_reg == GAP_FULL) && free_any;

    gap_next = gap_reg;
    if (spawn) begin
      gap_next = '0;
    end else if (tick && (gap_reg < GAP_FULL)) begin
      gap_next = gap_reg + GAP_W'(1);
    end

    active_next  = active_reg;
    col_next     = col_reg;
    y_next       = y_reg;
    missed_next  = 1'b0;
    spawned_next = spawn;
    hit_ok_next  = hit_any;
    hit_bad_next = start && hit_valid && !hit_any;

    // Per slot: hit clear beats retirement beats advance. The spawn target was
    // free before the edge, so it never collides with a clear in this cycle.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit_mask[i]) begin
        active_next[i] = 1'b0;
        y_next[i]      = '0;
        col_next[i]    = '0;
      end else if (tick && active_reg[i]) begin
        if (y_reg[i] >= Y_RETIRE) begin
          active_next[i] = 1'b0;
          y_next[i]      = '0;
          col_next[i]    = '0;
          missed_next    = 1'b1;
        end else begin
          y_next[i] = y_reg[i] + Y_W'(1);
        end
      end
      if (spawn && free_mask[i]) begin
        active_next[i] = 1'b1;
        y_next[i]      = '0;
        col_next[i]    = rand_word[COL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_reg <= '0;
      gap_reg     <= GAP_FULL;
      active_reg  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        col_reg[i] <= '0;
        y_reg[i]   <= '0;
      end
      spawned_reg <= 1'b0;
      hit_ok_reg  <= 1'b0;
      hit_bad_reg <= 1'b0;
      missed_reg  <= 1'b0;
    end else begin
      counter_reg <= counter_next;
      gap_reg     <= gap_next;
      active_reg  <= active_next;
      col_reg     <= col_next;
      y_reg       <= y_next;
      spawned_reg <= spawned_next;
      hit_ok_reg  <= hit_ok_next;
      hit_bad_reg <= hit_bad_next;
      missed_reg  <= missed_next;
    end
  end

  assign note_active = active_reg;
  assign spawned     = spawned_reg;
  assign hit_ok      = hit_ok_reg;
  assign hit_bad     = hit_bad_reg;
  assign note_missed = missed_reg;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_pack
    assign note_col[gi*COL_W +: COL_W] = col_reg[gi];
    assign note_y[gi*Y_W +: Y_W]       = y_reg[gi];
  end

`ifdef NOTE_LANE_STATS_EN
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;
  logic [16:0] miss_sum;

  // A retirement and a bad press can land in the same cycle: add both.
  assign miss_sum = {1'b0, miss_count_reg} + 17'(hit_bad_next) + 17'(missed_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit_ok_next && (hit_count_reg != 16'hFFFF)) begin
        hit_count_reg <= hit_count_reg + 16'd1;
      end
      miss_count_reg <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_note_lane_manager.sv
`timescale 1ns/1ps
module tb_note_lane_manager;

  localparam int Y_MAX   = 480;
  localparam int HIT_LO  = 440;
  localparam int HIT_HI  = 470;
  localparam int MIN_GAP = 8;
  localparam int THRESH  = 'h8000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] speed;
  logic [15:0] rand_word;
  logic        hit_valid;
  logic [1:0]  hit_column;
  logic [3:0]  note_active;
  logic [7:0]  note_col;
  logic [39:0] note_y;
  logic        spawned, hit_ok, hit_bad, note_missed;
`ifdef NOTE_LANE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  note_lane_manager dut (
    .clk(clk), .rst(rst), .start(start), .speed(speed), .rand_word(rand_word),
    .hit_valid(hit_valid), .hit_column(hit_column),
    .note_active(note_active), .note_col(note_col), .note_y(note_y),
    .spawned(spawned), .hit_ok(hit_ok), .hit_bad(hit_bad), .note_missed(note_missed)
`ifdef NOTE_LANE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: slot list with integer positions
  int         m_cnt, m_gap;
  bit         m_act [4];
  int         m_col [4];
  int         m_y   [4];
  logic [3:0] m_pulse;   // {spawned, hit_ok, hit_bad, note_missed}

  function automatic void model_reset();
    m_cnt = 0;
    m_gap = MIN_GAP;
    m_pulse = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0; m_col[i] = 0; m_y[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit st, input int sp, input int rw, input bit hv, input int hc);
    bit tick;
    int best;
    int free_slot;
    m_pulse = 4'b0000;
    if (!st) return;
    tick  = (m_cnt >= sp);
    m_cnt = tick ? 0 : m_cnt + 1;
    best = -1;
    free_slot = -1;
    for (int i = 0; i < 4; i++) begin
      if (!m_act[i] && free_slot < 0) free_slot = i;
      if (hv && m_act[i] && m_col[i] == hc && m_y[i] >= HIT_LO && m_y[i] <= HIT_HI
          && (best < 0 || m_y[i] > m_y[best])) best = i;
    end
    if (hv) begin
      if (best >= 0) begin
        m_act[best] = 0;
        m_pulse[2] = 1'b1;
      end else begin
        m_pulse[1] = 1'b1;
      end
    end
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (m_act[i]) begin
          if (m_y[i] >= Y_MAX) begin
            m_act[i] = 0;
            m_pulse[0] = 1'b1;
          end else begin
            m_y[i] = m_y[i] + 1;
          end
        end
      end
      if (rw > THRESH && m_gap == MIN_GAP && free_slot >= 0) begin
        m_act[free_slot] = 1;
        m_y[free_slot]   = 0;
        m_col[free_slot] = rw % 4;
        m_gap = 0;
        m_pulse[3] = 1'b1;
      end else if (m_gap < MIN_GAP) begin
        m_gap = m_gap + 1;
      end
    end
  endfunction

  function automatic logic [3:0] exp_active();
    logic [3:0] a;
    a = '0;
    for (int i = 0; i < 4; i++) a[i] = m_act[i];
    return a;
  endfunction

  function automatic logic [7:0] col_mask();
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*2 +: 2] = m_act[i] ? 2'b11 : 2'b00;
    return m;
  endfunction

  function automatic logic [7:0] exp_col();
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) e[i*2 +: 2] = m_act[i] ? 2'(m_col[i]) : 2'b00;
    return e;
  endfunction

  function automatic logic [39:0] y_mask();
    logic [39:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*10 +: 10] = m_act[i] ? 10'h3FF : 10'h000;
    return m;
  endfunction

  function automatic logic [39:0] exp_y();
    logic [39:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) e[i*10 +: 10] = m_act[i] ? 10'(m_y[i]) : 10'h000;
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
  task automatic step(input bit st, input int sp, input int rw, input bit hv, input int hc);
    start = st; speed = 20'(sp); rand_word = 16'(rw); hit_valid = hv; hit_column = 2'(hc);
    model_step(st, sp, rw, hv, hc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; speed = '0; rand_word = '0; hit_valid = 1'b0; hit_column = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (note_active !== 4'h0) begin errors++; $display("FAIL reset_active got=%h exp=0", note_active); end
    checks++; if (note_col !== 8'h00) begin errors++; $display("FAIL reset_col got=%h exp=0", note_col); end
    checks++; if (note_y !== 40'h0) begin errors++; $display("FAIL reset_y got=%h exp=0", note_y); end
    checks++; if ({spawned, hit_ok, hit_bad, note_missed} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0000", {spawned, hit_ok, hit_bad, note_missed});
    end
  endtask

  task automatic test_spawn();
    int nsp;
    bit exp_sp;
    nsp = 0;
    apply_reset();
    for (int k = 1; k <= 50; k++) begin
      step(1, 0, 'hFFFF, 0, 0);
      exp_sp = (k == 1 || k == 10 || k == 19 || k == 28);
      if (spawned) nsp++;
      checks++; if (spawned !== exp_sp) begin errors++; $display("FAIL spawn_timing k=%0d got=%b exp=%b", k, spawned, exp_sp); end
      checks++; if (note_active !== exp_active()) begin errors++; $display("FAIL spawn_active cyc=%0d got=%h exp=%h", cyc, note_active, exp_active()); end
      checks++; if ((note_col & col_mask()) !== exp_col()) begin errors++; $display("FAIL spawn_col cyc=%0d got=%h exp=%h", cyc, note_col & col_mask(), exp_col()); end
      checks++; if ((note_y & y_mask()) !== exp_y()) begin errors++; $display("FAIL spawn_y cyc=%0d got=%h exp=%h", cyc, note_y & y_mask(), exp_y()); end
    end
    checks++; if (nsp !== 4) begin errors++; $display("FAIL spawn_count got=%0d exp=4", nsp); end
    checks++; if (note_active !== 4'hF) begin errors++; $display("FAIL spawn_full got=%h exp=f", note_active); end
    checks++; if (note_col !== 8'hFF) begin errors++; $display("FAIL spawn_cols got=%h exp=ff", note_col); end
  endtask

  task automatic test_fall_miss();
    int nmiss;
    nmiss = 0;
    apply_reset();
    for (int k = 1; k <= 1500; k++) begin
      step(1, 2, (k <= 3) ? 'hFFFF : 0, 0, 0);
      if (note_missed) nmiss++;
      checks++; if (note_active !== exp_active()) begin errors++; $display("FAIL fall_active cyc=%0d got=%h exp=%h", cyc, note_active, exp_active()); end
      checks++; if ((note_y & y_mask()) !== exp_y()) begin errors++; $display("FAIL fall_y cyc=%0d got=%h exp=%h", cyc, note_y & y_mask(), exp_y()); end
      checks++; if ({spawned, hit_ok, hit_bad, note_missed} !== m_pulse) begin
        errors++; $display("FAIL fall_pulses cyc=%0d got=%b exp=%b", cyc, {spawned, hit_ok, hit_bad, note_missed}, m_pulse);
      end
    end
    checks++; if (nmiss !== 1) begin errors++; $display("FAIL fall_miss_count got=%0d exp=1", nmiss); end
    checks++; if (note_active !== 4'h0) begin errors++; $display("FAIL fall_cleared got=%h exp=0", note_active); end
  endtask

  task automatic test_hit_window();
    apply_reset();
    step(1, 0, 'h8001, 0, 0);
    for (int k = 0; k < 600 && m_y[0] != 455; k++) step(1, 0, 0, 0, 0);
    checks++; if (note_y[9:0] !== 10'd455) begin errors++; $display("FAIL hit_setup_y got=%0d exp=455", note_y[9:0]); end
    step(1, 0, 0, 1, 1);
    checks++; if ({hit_ok, hit_bad} !== 2'b10) begin errors++; $display("FAIL hit_ok_pulse got=%b exp=10", {hit_ok, hit_bad}); end
    checks++; if (note_active[0] !== 1'b0) begin errors++; $display("FAIL hit_clear got=%b exp=0", note_active[0]); end
    step(1, 0, 'h8001, 0, 0);
    for (int k = 0; k < 600 && m_y[0] != 439; k++) step(1, 0, 0, 0, 0);
    checks++; if (note_y[9:0] !== 10'd439) begin errors++; $display("FAIL early_setup_y got=%0d exp=439", note_y[9:0]); end
    step(1, 0, 0, 1, 1);
    checks++; if ({hit_ok, hit_bad} !== 2'b01) begin errors++; $display("FAIL hit_bad_pulse got=%b exp=01", {hit_ok, hit_bad}); end
    checks++; if (note_active[0] !== 1'b1) begin errors++; $display("FAIL early_kept got=%b exp=1", note_active[0]); end
    checks++; if (note_y[9:0] !== 10'd440) begin errors++; $display("FAIL early_advance got=%0d exp=440", note_y[9:0]); end
  endtask

  task automatic test_priority();
    apply_reset();
    step(1, 0, 'h8002, 0, 0);
    repeat (9) step(1, 0, 0, 0, 0);
    step(1, 0, 'h8002, 0, 0);
    checks++; if (note_active !== 4'b0011) begin errors++; $display("FAIL prio_two_notes got=%b exp=0011", note_active); end
    for (int k = 0; k < 600 && m_y[0] != 460; k++) step(1, 0, 0, 0, 0);
    checks++; if ({note_y[19:10], note_y[9:0]} !== {10'd450, 10'd460}) begin
      errors++; $display("FAIL prio_setup got=%0d/%0d exp=450/460", note_y[19:10], note_y[9:0]);
    end
    step(1, 0, 0, 1, 2);
    checks++; if (hit_ok !== 1'b1) begin errors++; $display("FAIL prio_hit_ok got=%b exp=1", hit_ok); end
    checks++; if (note_active !== 4'b0010) begin errors++; $display("FAIL prio_choice got=%b exp=0010", note_active); end
    checks++; if (note_y[19:10] !== 10'd451) begin errors++; $display("FAIL prio_survivor_y got=%0d exp=451", note_y[19:10]); end
  endtask

  // Runs on the state left by test_priority (one col-2 note inside the window).
  task automatic test_freeze();
    logic [39:0] snap_y;
    logic [3:0]  snap_a;
    repeat (3) step(1, 5, 0, 0, 0);
    snap_y = note_y;
    snap_a = note_active;
    for (int k = 0; k < 100; k++) begin
      step(0, 5, $urandom & 'hFFFF, 1, $urandom_range(0, 3));
      checks++; if ({spawned, hit_ok, hit_bad, note_missed} !== 4'b0000) begin
        errors++; $display("FAIL freeze_pulses k=%0d got=%b exp=0000", k, {spawned, hit_ok, hit_bad, note_missed});
      end
      checks++; if (note_y !== snap_y || note_active !== snap_a) begin
        errors++; $display("FAIL freeze_state k=%0d got=%h/%h exp=%h/%h", k, note_active, note_y, snap_a, snap_y);
      end
    end
    for (int k = 0; k < 12; k++) begin
      step(1, 5, 0, 0, 0);
      checks++; if ((note_y & y_mask()) !== exp_y()) begin errors++; $display("FAIL resume_y cyc=%0d got=%h exp=%h", cyc, note_y & y_mask(), exp_y()); end
    end
  endtask

  task automatic test_threshold();
    apply_reset();
    for (int k = 0; k < 60; k++) begin
      step(1, 0, 'h8000, 0, 0);
      checks++; if (spawned !== 1'b0) begin errors++; $display("FAIL threshold_spawn k=%0d got=%b exp=0", k, spawned); end
    end
    checks++; if (note_active !== 4'h0) begin errors++; $display("FAIL threshold_active got=%h exp=0", note_active); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1, 0, 'hFFFF, 0, 0);
    repeat (20) step(1, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (note_active !== 4'h0) begin errors++; $display("FAIL async_active got=%h exp=0", note_active); end
    checks++; if (note_y !== 40'h0 || note_col !== 8'h0) begin errors++; $display("FAIL async_pos got=%h/%h exp=0/0", note_y, note_col); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0, 0, 0);
      checks++; if (note_missed !== 1'b0 || note_active !== 4'h0) begin
        errors++; $display("FAIL async_after k=%0d missed=%b active=%h exp=0/0", k, note_missed, note_active);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 15) != 0), $urandom_range(0, 2), $urandom & 'hFFFF,
           ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
      checks++; if (note_active !== exp_active()) begin errors++; $display("FAIL rnd_active cyc=%0d got=%h exp=%h", cyc, note_active, exp_active()); end
      checks++; if ((note_col & col_mask()) !== exp_col()) begin errors++; $display("FAIL rnd_col cyc=%0d got=%h exp=%h", cyc, note_col & col_mask(), exp_col()); end
      checks++; if ((note_y & y_mask()) !== exp_y()) begin errors++; $display("FAIL rnd_y cyc=%0d got=%h exp=%h", cyc, note_y & y_mask(), exp_y()); end
      checks++; if ({spawned, hit_ok, hit_bad, note_missed} !== m_pulse) begin
        errors++; $display("FAIL rnd_pulses cyc=%0d got=%b exp=%b", cyc, {spawned, hit_ok, hit_bad, note_missed}, m_pulse);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; speed = '0; rand_word = '0; hit_valid = 1'b0; hit_column = '0;
    model_reset();
    test_reset();
    test_spawn();
    test_fall_miss();
    test_hit_window();
    test_priority();
    test_freeze();
    test_threshold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
